// File: rtl/fan_mode_cntr.sv
// fan_mode_cntr: fan speed mode FSM with a ramped PWM duty and a BCD auto-off countdown.
module fan_mode_cntr #(
   parameter int CLKS_PER_SEC = 100_000_000,
   parameter int RAMP_DIV     = 1_000_000,
   parameter int DUTY_LOW     = 30,
   parameter int DUTY_MID     = 60,
   parameter int DUTY_HIGH    = 99
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        btn_speed,
   input  logic        btn_timer,
   input  logic        btn_off,
   output logic [1:0]  mode,
   output logic [6:0]  duty,
   output logic        fan_on,
   output logic        timer_active,
   output logic [15:0] fnd_value
);
   typedef enum logic [1:0] {OFF, LOW, MID, HIGH} mode_e;
   localparam int SW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
   localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
   localparam logic [6:0] T_LOW  = 7'(DUTY_LOW  > 99 ? 99 : DUTY_LOW);
   localparam logic [6:0] T_MID  = 7'(DUTY_MID  > 99 ? 99 : DUTY_MID);
   localparam logic [6:0] T_HIGH = 7'(DUTY_HIGH > 99 ? 99 : DUTY_HIGH);
   mode_e       mode_q, mode_d;
   logic [6:0]  duty_q, duty_d, target;
   logic        active_q, active_d, fan_q;
   logic [11:0] rem_q, rem_d, rem_dec, preset_bcd;
   logic [1:0]  preset_q, preset_d, preset_nx;
   logic [SW-1:0] sec_q, sec_d;
   logic [RW-1:0] ramp_q;
   logic        sec_tick, expire, ramp_step, cancel;
   always_comb begin
      sec_tick   = active_q && sec_q == SW'(CLKS_PER_SEC - 1);
      expire     = sec_tick && rem_q == 12'h001;
      ramp_step  = ramp_q == RW'(RAMP_DIV - 1);
      rem_dec[3:0]  = rem_q[3:0] != 4'd0 ? rem_q[3:0] - 4'd1 : 4'd9;
      rem_dec[7:4]  = rem_q[3:0] != 4'd0 ? rem_q[7:4] : rem_q[7:4] != 4'd0 ? rem_q[7:4] - 4'd1 : 4'd9;
      rem_dec[11:8] = rem_q[7:0] != 8'h00 ? rem_q[11:8] : rem_q[11:8] - 4'd1;
      preset_nx  = preset_q + 2'd1;
      preset_bcd = preset_nx == 2'd1 ? 12'h060 : preset_nx == 2'd2 ? 12'h180 : preset_nx == 2'd3 ? 12'h300 : 12'h000;
      mode_d     = mode_q;
      active_d   = active_q;
      preset_d   = preset_q;
      rem_d      = sec_tick ? rem_dec : rem_q;
      sec_d      = active_q && !sec_tick ? sec_q + 1'b1 : '0;
      cancel     = 1'b0;
      // Priority chain; any event lower in the chain is dropped this cycle.
      if (btn_off || expire) begin
         mode_d = OFF;
         cancel = 1'b1;
      end else if (btn_speed) begin
         mode_d = mode_e'(mode_q + 2'd1);
         cancel = mode_q == HIGH;
      end else if (btn_timer && mode_q != OFF) begin
         preset_d = preset_nx;
         rem_d    = preset_bcd;
         active_d = preset_nx != 2'd0;
         sec_d    = '0;
      end
      if (cancel) begin
         active_d = 1'b0;
         rem_d    = 12'h000;
         preset_d = 2'd0;
         sec_d    = '0;
      end
      target = mode_q == LOW ? T_LOW : mode_q == MID ? T_MID : mode_q == HIGH ? T_HIGH : 7'd0;
      duty_d = !ramp_step ? duty_q : duty_q < target ? duty_q + 7'd1 : duty_q > target ? duty_q - 7'd1 : duty_q;
   end
   always_ff @(posedge clk) begin
      if (reset_p) begin
         mode_q   <= OFF;
         duty_q   <= '0;
         active_q <= 1'b0;
         fan_q    <= 1'b0;
         rem_q    <= '0;
         preset_q <= '0;
         sec_q    <= '0;
         ramp_q   <= '0;
      end else begin
         mode_q   <= mode_d;
         duty_q   <= duty_d;
         active_q <= active_d;
         fan_q    <= mode_d != OFF || duty_d != 7'd0;
         rem_q    <= rem_d;
         preset_q <= preset_d;
         sec_q    <= sec_d;
         ramp_q   <= ramp_step ? '0 : ramp_q + 1'b1;
      end
   end
   assign mode         = mode_q;
   assign duty         = duty_q;
   assign fan_on       = fan_q;
   assign timer_active = active_q;
   assign fnd_value    = {2'b00, mode_q, rem_q};
endmodule

// File: tb/tb_fan_mode_cntr.sv
// tb_fan_mode_cntr: directed checks of mode sequencing, duty ramp, BCD countdown and event priority.
module tb_fan_mode_cntr;
   logic        clk = 1'b0, reset_p = 1'b1, btn_speed = 1'b0, btn_timer = 1'b0, btn_off = 1'b0;
   logic [1:0]  mode;
   logic [6:0]  duty, d0;
   logic        fan_on, timer_active;
   logic [15:0] fnd_value;
   int          checks = 0, errors = 0;

   fan_mode_cntr #(.CLKS_PER_SEC(10), .RAMP_DIV(2)) dut (
      .clk(clk), .reset_p(reset_p), .btn_speed(btn_speed), .btn_timer(btn_timer), .btn_off(btn_off),
      .mode(mode), .duty(duty), .fan_on(fan_on), .timer_active(timer_active), .fnd_value(fnd_value)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_duty(input string tag, input logic [6:0] t, input int budget);
      for (int i = 0; i < budget && duty !== t; i++) tick(1);
      chk(tag, 16'(duty), 16'(t));
   endtask

   task automatic press_speed();
      btn_speed = 1'b1; tick(1); btn_speed = 1'b0;
   endtask

   task automatic press_timer();
      btn_timer = 1'b1; tick(1); btn_timer = 1'b0;
   endtask

   initial begin
      tick(2);
      reset_p = 1'b0;
      tick(100);
      chk("rst_mode", 16'(mode), 16'd0);
      chk("rst_duty", 16'(duty), 16'd0);
      chk("rst_fan", 16'(fan_on), 16'd0);
      chk("rst_active", 16'(timer_active), 16'd0);
      chk("rst_fnd", fnd_value, 16'h0000);
      press_timer();
      tick(1);
      chk("off_timer_active", 16'(timer_active), 16'd0);
      chk("off_timer_fnd", fnd_value, 16'h0000);

      press_speed();
      chk("low_mode", 16'(mode), 16'd1);
      chk("low_fnd", fnd_value, 16'h1000);
      chk("low_fan", 16'(fan_on), 16'd1);
      d0 = duty;
      tick(2);
      chk("ramp_rate", 16'(duty), 16'(d0 + 7'd1));
      wait_duty("low_settle", 7'd30, 200);
      tick(10);
      chk("low_hold", 16'(duty), 16'd30);

      press_speed();
      press_speed();
      chk("high_mode", 16'(mode), 16'd3);
      wait_duty("high_settle", 7'd99, 300);
      tick(6);
      chk("high_hold", 16'(duty), 16'd99);
      btn_off = 1'b1; tick(1); btn_off = 1'b0;
      chk("off_mode", 16'(mode), 16'd0);
      chk("off_fan_ramp", 16'(fan_on), 16'd1);
      wait_duty("off_rampdown", 7'd0, 400);
      chk("off_fan_end", 16'(fan_on), 16'd0);

      press_speed();
      press_speed();
      chk("mid_mode", 16'(mode), 16'd2);
      wait_duty("mid_settle", 7'd60, 300);
      press_timer();
      chk("t60_active", 16'(timer_active), 16'd1);
      chk("t60_fnd", fnd_value, 16'h2060);
      tick(10);
      chk("t59_fnd", fnd_value, 16'h2059);
      tick(580);
      chk("t01_fnd", fnd_value, 16'h2001);
      tick(9);
      chk("t01_still_active", 16'(timer_active), 16'd1);
      tick(1);
      chk("exp_mode", 16'(mode), 16'd0);
      chk("exp_active", 16'(timer_active), 16'd0);
      chk("exp_fnd", fnd_value, 16'h0000);
      chk("exp_fan", 16'(fan_on), 16'd1);
      wait_duty("exp_rampdown", 7'd0, 200);
      chk("exp_fan_end", 16'(fan_on), 16'd0);

      press_speed();
      press_timer();
      chk("p060", fnd_value, 16'h1060);
      press_timer();
      chk("p180", fnd_value, 16'h1180);
      press_timer();
      chk("p300", fnd_value, 16'h1300);
      tick(10);
      chk("b299", fnd_value, 16'h1299);
      press_timer();
      chk("p000_fnd", fnd_value, 16'h1000);
      chk("p000_active", 16'(timer_active), 16'd0);
      press_timer();
      press_timer();
      chk("p180_again", fnd_value, 16'h1180);
      tick(800);
      chk("b100", fnd_value, 16'h1100);
      tick(10);
      chk("b099", fnd_value, 16'h1099);
      press_speed();
      chk("speed_keeps_timer", fnd_value, 16'h2099);
      chk("speed_keeps_active", 16'(timer_active), 16'd1);

      tick(988);
      chk("pre_exp_fnd", fnd_value, 16'h2001);
      press_speed();
      chk("exp_vs_speed_mode", 16'(mode), 16'd0);
      chk("exp_vs_speed_fnd", fnd_value, 16'h0000);

      press_speed();
      chk("low_again", 16'(mode), 16'd1);
      btn_off = 1'b1; btn_speed = 1'b1; tick(1); btn_off = 1'b0; btn_speed = 1'b0;
      chk("off_vs_speed", 16'(mode), 16'd0);

      wait_duty("pre_rst_zero", 7'd0, 200);
      press_speed();
      press_speed();
      press_timer();
      wait_duty("mid_45", 7'd45, 200);
      reset_p = 1'b1; tick(1);
      chk("mrst_mode", 16'(mode), 16'd0);
      chk("mrst_duty", 16'(duty), 16'd0);
      chk("mrst_fan", 16'(fan_on), 16'd0);
      chk("mrst_active", 16'(timer_active), 16'd0);
      chk("mrst_fnd", fnd_value, 16'h0000);
      reset_p = 1'b0;
      tick(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
